gemm_tile_unit: RTL and testbench
=================================

Name: gemm_tile_unit

Overview:
- Registered VTA-style GEMM tile: one vector-matrix multiply-accumulate per accepted beat, o[i] = a[i] + sum over k of inp[k]*wgt[i][k].
- Sits between the input/weight scratchpad BRAM read ports (single-port, 1-cycle read) and the accumulator register file of the GEMM core.
- Pure datapath with a valid pipeline; no backpressure.

Parameters:
- INP_WIDTH, 8, bit width of one signed input element.
- WGT_WIDTH, 8, bit width of one signed weight element.
- ACC_WIDTH, 32, bit width of one signed accumulator/output element.
- BLOCK_IN, 16, input vector length (reduction dimension).
- BLOCK_OUT, 16, output vector length.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands valid this cycle.
- clr, input, 1, with in_valid: produce zero result (accumulator reset op).
- i_tensor, input, INP_WIDTH*BLOCK_IN, element k at bits [k*INP_WIDTH +: INP_WIDTH].
- w_tensor, input, WGT_WIDTH*BLOCK_OUT*BLOCK_IN, element (i,k) at flat index i*BLOCK_IN+k.
- a_tensor, input, ACC_WIDTH*BLOCK_OUT, element i at bits [i*ACC_WIDTH +: ACC_WIDTH].
- out_valid, output, 1, o_tensor holds a new result.
- o_tensor, output, ACC_WIDTH*BLOCK_OUT, same packing as a_tensor.

Behaviour:
- Reset: on a clk edge with rst=1, out_valid<=0 and o_tensor<=0.
- Reset mid-operation discards all in-flight beats; no partial result is emitted.
- Arithmetic, per output i:
  - All elements are two's-complement signed.
  - Each product inp[k]*wgt[i][k] is formed at INP_WIDTH+WGT_WIDTH bits and sign-extended to ACC_WIDTH.
  - Products are summed with a[i] modulo 2^ACC_WIDTH. Overflow wraps silently; no saturation and no flags.
- clr=1 with in_valid=1: o_tensor<=0, out_valid<=1; operands are ignored.
- clr is ignored when in_valid=0.
- Latency: result for the beat accepted at edge N appears on o_tensor with out_valid=1 after edge N+1 (one register stage).
- Throughput: one beat per cycle; back-to-back beats give back-to-back results.
- in_valid=0:
  - out_valid drops to 0 on the next edge.
  - o_tensor holds its last value and does not return to zero.
- No handshake: the consumer must accept every out_valid cycle.
- Operand inputs are sampled only when in_valid=1; X on idle cycles must not propagate into o_tensor.

Optional Feature:
- GEMM_PIPE_EN defined:
  - Adds a register stage holding all BLOCK_OUT*BLOCK_IN sign-extended products, plus delayed a_tensor, clr and valid.
  - Latency becomes 2 cycles; throughput stays 1/cycle.
  - rst clears both stages' valid bits.
- GEMM_PIPE_EN undefined: single-stage, 1-cycle latency as above. Results are bit-identical in both builds.

Decomposition:
- Shared package gemm_pkg:
  - width constants INP_WIDTH, WGT_WIDTH, ACC_WIDTH, BLOCK_IN, BLOCK_OUT;
  - derived IT_WIDTH, WT_WIDTH, AT_WIDTH;
  - signed element typedefs inp_t, wgt_t, acc_t.
- One natural sub-module, gemm_dot_row: combinational signed dot product of one BLOCK_IN input vector with one weight row plus one accumulator element. It is instantiated BLOCK_OUT times via generate.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> out_valid=0 and o_tensor=0 every cycle, including after rst falls.
- Identity:
  - inp[k]=k+1, wgt[i][k]=1 when i==k else 0, a=0;
  - -> 1 cycle later o[i]=i+1, out_valid=1 for exactly one cycle.
- Signed and accumulate:
  - all inp=-128, all wgt=-128, a[i]=i;
  - -> o[i]=16*16384+i=262144+i.
  - Then all inp=127, all wgt=-128, a=0 -> o[i]=-260096.
- Wrap-around: all inp=-128, all wgt=-128, a[i]=0x7FFF_FFFF -> o[i]=0x7FFF_FFFF+262144 mod 2^32 = 0x8003_FFFF.
- clr and streaming:
  - three back-to-back beats, the middle one with clr=1 and nonzero operands;
  - -> three consecutive out_valid cycles with middle result all zeros.
  - Then an in_valid=0 gap -> o_tensor holds the third result.
- Reset mid-stream: assert rst in the same cycle as a valid beat -> no out_valid follows, and o_tensor=0 after that edge. With GEMM_PIPE_EN, repeat with rst one cycle after the beat -> no result emitted.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared widths, flattened tensor widths and signed element types
// for the GEMM tile. Also provides the product helper used by every datapath
// stage. Optional build macro used by gemm_tile_unit: GEMM_PIPE_EN.
package gemm_pkg;

    localparam int INP_WIDTH  = 8;
    localparam int WGT_WIDTH  = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int BLOCK_IN   = 16;
    localparam int BLOCK_OUT  = 16;

    // Full-precision product width before widening to the accumulator.
    localparam int PROD_WIDTH = INP_WIDTH + WGT_WIDTH;

    // Flattened tensor port widths.
    localparam int IT_WIDTH   = INP_WIDTH * BLOCK_IN;
    localparam int WT_WIDTH   = WGT_WIDTH * BLOCK_OUT * BLOCK_IN;
    localparam int AT_WIDTH   = ACC_WIDTH * BLOCK_OUT;

    typedef logic signed [INP_WIDTH-1:0] inp_t;
    typedef logic signed [WGT_WIDTH-1:0] wgt_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    // Exact signed product at PROD_WIDTH bits, then sign-extended to the
    // accumulator width so that the following adds wrap modulo 2^ACC_WIDTH.
    function automatic acc_t sext_prod(input inp_t x, input wgt_t w);
        logic signed [PROD_WIDTH-1:0] p;
        p = PROD_WIDTH'(x) * PROD_WIDTH'(w);
        return {{(ACC_WIDTH - PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
    endfunction

endpackage

// File: rtl/gemm_dot_row.sv
// gemm_dot_row: combinational signed dot product of one input vector with one
// weight row, added onto one accumulator element. Wraps modulo 2^ACC_WIDTH.
module gemm_dot_row
    import gemm_pkg::*;
(
    input  logic [IT_WIDTH-1:0]            inp_vec,
    input  logic [WGT_WIDTH*BLOCK_IN-1:0]  wgt_row,
    input  logic [ACC_WIDTH-1:0]           acc_in,
    output logic [ACC_WIDTH-1:0]           dot
);

    acc_t prod [BLOCK_IN];

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_IN; gi++) begin : g_prod
            assign prod[gi] = sext_prod(inp_t'(inp_vec[gi*INP_WIDTH +: INP_WIDTH]),
                                        wgt_t'(wgt_row[gi*WGT_WIDTH +: WGT_WIDTH]));
        end
    endgenerate

    // Reduction: accumulator plus all widened products, silent wrap on overflow.
    always_comb begin
        acc_t sum;
        sum = acc_t'(acc_in);
        for (int k = 0; k < BLOCK_IN; k++) begin
            sum = sum + prod[k];
        end
        dot = sum;
    end

endmodule

// File: rtl/gemm_tile_unit.sv
// gemm_tile_unit: registered GEMM tile, o[i] = a[i] + sum_k inp[k]*wgt[i][k].
// One beat per cycle, no backpressure. clr with in_valid yields an all-zero
// result. Operands are only looked at when in_valid is high, so idle-cycle X
// never reaches o_tensor, and o_tensor holds its value between results.
// Build option GEMM_PIPE_EN: inserts a product register stage (2-cycle
// latency, same throughput, bit-identical results). Default: 1-cycle latency.
module gemm_tile_unit
    import gemm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 clr,
    input  logic [IT_WIDTH-1:0]  i_tensor,
    input  logic [WT_WIDTH-1:0]  w_tensor,
    input  logic [AT_WIDTH-1:0]  a_tensor,
    output logic                 out_valid,
    output logic [AT_WIDTH-1:0]  o_tensor
);

    // Combinational result for the beat feeding the output register.
    logic [AT_WIDTH-1:0] result_next;
    // Valid / clear qualifiers aligned with result_next.
    logic                stage_valid;
    logic                stage_clr;

    genvar gi;

`ifdef GEMM_PIPE_EN

    // Stage 1: every widened product plus the accumulator operands and flags.
    acc_t                prod_reg [BLOCK_OUT][BLOCK_IN];
    logic [AT_WIDTH-1:0] acc_reg;
    logic                clr_reg;
    logic                valid_reg;

    // Capture products only for accepted beats; reset kills the in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                clr_reg <= clr;
                acc_reg <= a_tensor;
                for (int i = 0; i < BLOCK_OUT; i++) begin
                    for (int k = 0; k < BLOCK_IN; k++) begin
                        prod_reg[i][k] <= sext_prod(
                            inp_t'(i_tensor[k*INP_WIDTH +: INP_WIDTH]),
                            wgt_t'(w_tensor[(i*BLOCK_IN + k)*WGT_WIDTH +: WGT_WIDTH]));
                    end
                end
            end
        end
    end

    // Stage 2: per-row reduction of the registered products.
    generate
        for (gi = 0; gi < BLOCK_OUT; gi++) begin : g_row_sum
            acc_t row_sum;

            // Accumulator element plus the row's stored products.
            always_comb begin
                acc_t s;
                s = acc_t'(acc_reg[gi*ACC_WIDTH +: ACC_WIDTH]);
                for (int k = 0; k < BLOCK_IN; k++) begin
                    s = s + prod_reg[gi][k];
                end
                row_sum = s;
            end

            assign result_next[gi*ACC_WIDTH +: ACC_WIDTH] = row_sum;
        end
    endgenerate

    assign stage_valid = valid_reg;
    assign stage_clr   = clr_reg;

`else

    // Single stage: one dot-product row per output element, fed directly.
    generate
        for (gi = 0; gi < BLOCK_OUT; gi++) begin : g_row
            logic [ACC_WIDTH-1:0] row_dot;

            gemm_dot_row u_dot_row (
                .inp_vec (i_tensor),
                .wgt_row (w_tensor[gi*BLOCK_IN*WGT_WIDTH +: BLOCK_IN*WGT_WIDTH]),
                .acc_in  (a_tensor[gi*ACC_WIDTH +: ACC_WIDTH]),
                .dot     (row_dot)
            );

            assign result_next[gi*ACC_WIDTH +: ACC_WIDTH] = row_dot;
        end
    endgenerate

    assign stage_valid = in_valid;
    assign stage_clr   = clr;

`endif

    // Output register: load on valid (zero for clr), otherwise hold the value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o_tensor  <= '0;
        end else begin
            out_valid <= stage_valid;
            if (stage_valid) begin
                o_tensor <= stage_clr ? '0 : result_next;
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_unit.sv
// tb_gemm_tile_unit: directed plus randomized stimulus for gemm_tile_unit,
// checked every cycle against an arithmetic reference and a latency delay line.
// Honours GEMM_PIPE_EN for the expected latency.
module tb_gemm_tile_unit;
    import gemm_pkg::*;

`ifdef GEMM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                clr;
    logic [IT_WIDTH-1:0] i_tensor;
    logic [WT_WIDTH-1:0] w_tensor;
    logic [AT_WIDTH-1:0] a_tensor;
    logic                out_valid;
    logic [AT_WIDTH-1:0] o_tensor;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference state: beats in flight and the expected output register.
    logic                dl_v [LAT];
    logic [AT_WIDTH-1:0] dl_o [LAT];
    logic                exp_valid;
    logic [AT_WIDTH-1:0] exp_o;

    always #5 clk = ~clk;

    gemm_tile_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .clr       (clr),
        .i_tensor  (i_tensor),
        .w_tensor  (w_tensor),
        .a_tensor  (a_tensor),
        .out_valid (out_valid),
        .o_tensor  (o_tensor)
    );

    task automatic check_eq(input string tag, input logic [AT_WIDTH-1:0] got,
                            input logic [AT_WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Plain integer GEMM: 64-bit exact sum, then keep the low ACC_WIDTH bits.
    function automatic logic [AT_WIDTH-1:0] ref_gemm(input logic [IT_WIDTH-1:0] it,
                                                     input logic [WT_WIDTH-1:0] wt,
                                                     input logic [AT_WIDTH-1:0] at);
        logic [AT_WIDTH-1:0] r;
        longint              s;
        logic signed [INP_WIDTH-1:0] x;
        logic signed [WGT_WIDTH-1:0] w;
        logic signed [ACC_WIDTH-1:0] a;
        r = '0;
        for (int i = 0; i < BLOCK_OUT; i++) begin
            a = at[i*ACC_WIDTH +: ACC_WIDTH];
            s = longint'(a);
            for (int k = 0; k < BLOCK_IN; k++) begin
                x = it[k*INP_WIDTH +: INP_WIDTH];
                w = wt[(i*BLOCK_IN + k)*WGT_WIDTH +: WGT_WIDTH];
                s = s + longint'(x) * longint'(w);
            end
            r[i*ACC_WIDTH +: ACC_WIDTH] = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // One clock: update the reference at the edge, compare at the falling edge.
    task automatic cycle(input string tag);
        logic [AT_WIDTH-1:0] bo;
        @(posedge clk);
        if (rst) begin
            for (int j = 0; j < LAT; j++) dl_v[j] = 1'b0;
            exp_valid = 1'b0;
            exp_o     = '0;
        end else begin
            bo = '0;
            if (in_valid && !clr) bo = ref_gemm(i_tensor, w_tensor, a_tensor);
            for (int j = LAT - 1; j > 0; j--) begin
                dl_v[j] = dl_v[j-1];
                dl_o[j] = dl_o[j-1];
            end
            dl_v[0] = in_valid;
            dl_o[0] = bo;
            exp_valid = dl_v[LAT-1];
            if (dl_v[LAT-1]) exp_o = dl_o[LAT-1];
        end
        @(negedge clk);
        check_eq({tag, "_valid"}, AT_WIDTH'(out_valid), AT_WIDTH'(exp_valid));
        check_eq({tag, "_o"}, o_tensor, exp_o);
        if (exp_valid) begin
            txn++;
            $display("txn %0d %s o0=%0h o15=%0h", txn, tag,
                     o_tensor[0 +: ACC_WIDTH], o_tensor[15*ACC_WIDTH +: ACC_WIDTH]);
        end
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        clr      = 1'b0;
        i_tensor = 'x;
        w_tensor = 'x;
        a_tensor = 'x;
        cycle(tag);
    endtask

    task automatic beat(input logic c, input string tag);
        in_valid = 1'b1;
        clr      = c;
        cycle(tag);
    endtask

    task automatic rand_ops();
        for (int j = 0; j < IT_WIDTH / 32; j++) i_tensor[j*32 +: 32] = $urandom();
        for (int j = 0; j < WT_WIDTH / 32; j++) w_tensor[j*32 +: 32] = $urandom();
        for (int j = 0; j < AT_WIDTH / 32; j++) a_tensor[j*32 +: 32] = $urandom();
    endtask

    task automatic fill_all(input logic [INP_WIDTH-1:0] xv, input logic [WGT_WIDTH-1:0] wv);
        for (int k = 0; k < BLOCK_IN; k++) i_tensor[k*INP_WIDTH +: INP_WIDTH] = xv;
        for (int n = 0; n < BLOCK_IN * BLOCK_OUT; n++) w_tensor[n*WGT_WIDTH +: WGT_WIDTH] = wv;
    endtask

    initial begin
        logic [AT_WIDTH-1:0] third;
        for (int j = 0; j < LAT; j++) dl_v[j] = 1'b0;
        exp_valid = 1'b0;
        exp_o     = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        clr       = 1'b0;
        i_tensor  = 'x;
        w_tensor  = 'x;
        a_tensor  = 'x;

        // Reset held two cycles, then idle.
        cycle("rst0");
        cycle("rst1");
        rst = 1'b0;
        idle("idle0");
        idle("idle1");

        // Identity weights.
        for (int k = 0; k < BLOCK_IN; k++) i_tensor[k*INP_WIDTH +: INP_WIDTH] = INP_WIDTH'(k + 1);
        for (int i = 0; i < BLOCK_OUT; i++)
            for (int k = 0; k < BLOCK_IN; k++)
                w_tensor[(i*BLOCK_IN + k)*WGT_WIDTH +: WGT_WIDTH] = (i == k) ? 8'd1 : 8'd0;
        a_tensor = '0;
        beat(1'b0, "ident");
        idle("ident_g0");
        idle("ident_g1");
        check_eq("ident_o3", AT_WIDTH'(o_tensor[3*ACC_WIDTH +: ACC_WIDTH]), AT_WIDTH'(4));

        // Most-negative operands with accumulate.
        fill_all(8'h80, 8'h80);
        for (int i = 0; i < BLOCK_OUT; i++) a_tensor[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(i);
        beat(1'b0, "neg");
        idle("neg_g0");
        idle("neg_g1");
        check_eq("neg_o5", AT_WIDTH'(o_tensor[5*ACC_WIDTH +: ACC_WIDTH]), AT_WIDTH'(262149));

        // Mixed signs.
        fill_all(8'h7F, 8'h80);
        a_tensor = '0;
        beat(1'b0, "mix");
        idle("mix_g0");
        idle("mix_g1");
        check_eq("mix_o0", AT_WIDTH'(o_tensor[0 +: ACC_WIDTH]), AT_WIDTH'(32'hFFFC_0800));

        // Accumulator wrap-around.
        fill_all(8'h80, 8'h80);
        for (int i = 0; i < BLOCK_OUT; i++) a_tensor[i*ACC_WIDTH +: ACC_WIDTH] = 32'h7FFF_FFFF;
        beat(1'b0, "wrap");
        idle("wrap_g0");
        idle("wrap_g1");
        check_eq("wrap_o15", AT_WIDTH'(o_tensor[15*ACC_WIDTH +: ACC_WIDTH]), AT_WIDTH'(32'h8003_FFFF));

        // Streaming with clr in the middle, then a gap that must hold.
        rand_ops();
        beat(1'b0, "strm0");
        rand_ops();
        beat(1'b1, "strm_clr");
        rand_ops();
        third = ref_gemm(i_tensor, w_tensor, a_tensor);
        beat(1'b0, "strm2");
        idle("strm_g0");
        idle("strm_g1");
        idle("strm_g2");
        check_eq("strm_hold", o_tensor, third);

        // Reset coincident with a valid beat.
        rand_ops();
        rst = 1'b1;
        beat(1'b0, "rst_beat");
        rst = 1'b0;
        idle("rst_b_g0");
        idle("rst_b_g1");

        // Reset one cycle after a valid beat.
        rand_ops();
        beat(1'b0, "pre_rst");
        rst = 1'b1;
        idle("rst_after");
        rst = 1'b0;
        idle("rst_a_g0");
        idle("rst_a_g1");

        // Randomized traffic with occasional clr and reset.
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) != 0) begin
                rand_ops();
                beat(($urandom_range(0, 7) == 0), "rnd");
            end else begin
                idle("rnd_idle");
            end
        end
        rst = 1'b0;
        idle("end0");
        idle("end1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
